pe_sched: RTL and testbench

//  Sequencer for a single pe_unit MAC/round datapath. Runs one tile job:
//  - accepts a streamed operand pairs into S accumulator slots over K dot-product steps
//  - then rounds and drains each slot in order, emitting one 16-bit result per slot.

---
 rtl/pe_sched.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pe_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_sched.sv
// pe_sched: sequences one tile job on a pe_unit (MAC over K x S operand pairs, then round/drain per slot).
// Optional macro PE_SCHED_PERF_EN adds the perf_stall_cnt port counting MAC-state stall cycles.
module pe_sched #(
    parameter int para_int_bits  = 7,
    parameter int para_frac_bits = 9,
    parameter int SLOT_NUM       = 8,
    parameter int K_W            = 8,
    localparam int W             = para_int_bits + para_frac_bits
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [K_W-1:0] cfg_k,
    input  logic [3:0]     cfg_slots,
    input  logic           op_valid,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic           op_ready,
    output logic [W-1:0]   pe_data_in_1,
    output logic [W-1:0]   pe_data_in_2,
    output logic [3:0]     pe_add_number,
    output logic           pe_keep,
    output logic           pe_rounder_en,
    input  logic [W-1:0]   pe_data_out,
    input  logic           pe_rounder_valid,
    output logic           res_valid,
    output logic [W-1:0]   res_data,
    output logic [3:0]     res_slot,
    output logic           busy,
`ifdef PE_SCHED_PERF_EN
    output logic [15:0]    perf_stall_cnt,
`endif
    output logic           done
);

    localparam logic [3:0] SLOT_MAX = 4'(SLOT_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_ROUND = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t         state_r, next_state;
    logic [3:0]     slot_r, slot_s;
    logic [K_W-1:0] k_r, k_s;
    logic [1:0]     flush_r, flush_s;
    logic [K_W-1:0] k_max_r;
    logic [3:0]     s_max_r;
    logic [3:0]     slots_clamped_s;

    logic           accept_s;
    logic           op_ready_s, op_ready_r;
    logic [W-1:0]   din1_s, din1_r, din2_s, din2_r;
    logic [3:0]     add_s, add_r;
    logic           keep_s, keep_r;
    logic           ren_s, ren_r;
    logic           res_valid_s, res_valid_r;
    logic [W-1:0]   res_data_s, res_data_r;
    logic [3:0]     res_slot_s, res_slot_r;
    logic           busy_s, busy_r;
    logic           done_s, done_r;

    assign slots_clamped_s = (cfg_slots > SLOT_MAX) ? SLOT_MAX : cfg_slots;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            slot_r  <= 4'd0;
            k_r     <= '0;
            flush_r <= 2'd0;
        end else begin
            state_r <= next_state;
            slot_r  <= slot_s;
            k_r     <= k_s;
            flush_r <= flush_s;
        end
    end

    // Job configuration, captured only when a start is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_max_r <= '0;
            s_max_r <= 4'd0;
        end else if (state_r == ST_IDLE && start) begin
            k_max_r <= cfg_k;
            s_max_r <= slots_clamped_s;
        end else begin
            k_max_r <= k_max_r;
            s_max_r <= s_max_r;
        end
    end

    // Next-state and counter update; slot is the inner loop, k the outer
    always_comb begin
        next_state = state_r;
        slot_s     = slot_r;
        k_s        = k_r;
        flush_s    = flush_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_MAC;
                    slot_s     = 4'd0;
                    k_s        = '0;
                    flush_s    = 2'd0;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (op_valid) begin
                    if (slot_r == s_max_r) begin
                        slot_s = 4'd0;
                        if (k_r == k_max_r) begin
                            k_s        = '0;
                            next_state = ST_FLUSH;
                        end else begin
                            k_s = k_r + K_W'(1);
                        end
                    end else begin
                        slot_s = slot_r + 4'd1;
                    end
                end else begin
                    next_state = ST_MAC;
                end
            end
            ST_FLUSH: begin
                if (flush_r == 2'd2) begin
                    flush_s    = 2'd0;
                    slot_s     = 4'd0;
                    next_state = ST_ROUND;
                end else begin
                    flush_s = flush_r + 2'd1;
                end
            end
            ST_ROUND: begin
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (pe_rounder_valid) begin
                    if (slot_r == s_max_r) begin
                        slot_s     = 4'd0;
                        next_state = ST_DONE;
                    end else begin
                        slot_s     = slot_r + 4'd1;
                        next_state = ST_ROUND;
                    end
                end else begin
                    next_state = ST_WAIT;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
                slot_s     = 4'd0;
                k_s        = '0;
                flush_s    = 2'd0;
            end
        endcase
    end

    // Next values of the registered outputs; flags follow next_state so they align with the state
    always_comb begin
        accept_s    = (state_r == ST_MAC) && op_valid;
        op_ready_s  = (next_state == ST_MAC);
        busy_s      = (next_state == ST_MAC) || (next_state == ST_FLUSH) ||
                      (next_state == ST_ROUND) || (next_state == ST_WAIT);
        done_s      = (next_state == ST_DONE);
        ren_s       = (next_state == ST_ROUND);
        keep_s      = !accept_s;
        din1_s      = din1_r;
        din2_s      = din2_r;
        add_s       = add_r;
        res_valid_s = 1'b0;
        res_data_s  = res_data_r;
        res_slot_s  = res_slot_r;
        if (accept_s) begin
            din1_s = op_a;
            din2_s = op_b;
            add_s  = slot_r;
        end else if (next_state == ST_ROUND) begin
            add_s = slot_s;
        end else begin
            add_s = add_r;
        end
        if (state_r == ST_WAIT && pe_rounder_valid) begin
            res_valid_s = 1'b1;
            res_data_s  = pe_data_out;
            res_slot_s  = slot_r;
        end else begin
            res_valid_s = 1'b0;
        end
    end

    // Output registers; pe_keep idles high so the PE never accumulates outside MAC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_ready_r  <= 1'b0;
            din1_r      <= '0;
            din2_r      <= '0;
            add_r       <= 4'd0;
            keep_r      <= 1'b1;
            ren_r       <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_slot_r  <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            op_ready_r  <= op_ready_s;
            din1_r      <= din1_s;
            din2_r      <= din2_s;
            add_r       <= add_s;
            keep_r      <= keep_s;
            ren_r       <= ren_s;
            res_valid_r <= res_valid_s;
            res_data_r  <= res_data_s;
            res_slot_r  <= res_slot_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

`ifdef PE_SCHED_PERF_EN
    logic [15:0] perf_stall_cnt_r;

    // Saturating count of MAC cycles without an operand pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_r <= 16'd0;
        end else if (state_r == ST_IDLE && start) begin
            perf_stall_cnt_r <= 16'd0;
        end else if (state_r == ST_MAC && !op_valid && perf_stall_cnt_r != 16'hFFFF) begin
            perf_stall_cnt_r <= perf_stall_cnt_r + 16'd1;
        end else begin
            perf_stall_cnt_r <= perf_stall_cnt_r;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
`endif

    assign op_ready      = op_ready_r;
    assign pe_data_in_1  = din1_r;
    assign pe_data_in_2  = din2_r;
    assign pe_add_number = add_r;
    assign pe_keep       = keep_r;
    assign pe_rounder_en = ren_r;
    assign res_valid     = res_valid_r;
    assign res_data      = res_data_r;
    assign res_slot      = res_slot_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_pe_sched.sv
// Directed testbench for pe_sched with a small behavioural pe_unit model (MAC into slots, 3-cycle rounder).
module tb_pe_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_k;
    logic [3:0]  cfg_slots;
    logic        op_valid;
    logic [15:0] op_a, op_b;
    logic        op_ready;
    logic [15:0] pe_data_in_1, pe_data_in_2;
    logic [3:0]  pe_add_number;
    logic        pe_keep, pe_rounder_en;
    logic [15:0] pe_data_out;
    logic        pe_rounder_valid;
    logic        res_valid;
    logic [15:0] res_data;
    logic [3:0]  res_slot;
    logic        busy, done;
`ifdef PE_SCHED_PERF_EN
    logic [15:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int bubble_err;
    logic [15:0] res_q[$];
    logic [3:0]  slot_q[$];

    always #5 clk = ~clk;

    pe_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_slots(cfg_slots),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .pe_data_in_1(pe_data_in_1), .pe_data_in_2(pe_data_in_2),
        .pe_add_number(pe_add_number), .pe_keep(pe_keep), .pe_rounder_en(pe_rounder_en),
        .pe_data_out(pe_data_out), .pe_rounder_valid(pe_rounder_valid),
        .res_valid(res_valid), .res_data(res_data), .res_slot(res_slot),
        .busy(busy),
`ifdef PE_SCHED_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .done(done)
    );

    // Behavioural PE: Q7.9 product accumulated into a slot when keep is low; rounder answers 3 cycles later
    logic [15:0]        acc [16];
    logic [2:0]         rpipe;
    logic [15:0]        rd_hold;
    logic signed [31:0] prod;
    assign prod = $signed(pe_data_in_1) * $signed(pe_data_in_2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) acc[i] <= 16'd0;
            rpipe            <= 3'd0;
            rd_hold          <= 16'd0;
            pe_rounder_valid <= 1'b0;
            pe_data_out      <= 16'd0;
        end else begin
            if (!pe_keep) acc[pe_add_number] <= acc[pe_add_number] + 16'(prod >>> 9);
            if (pe_rounder_en) begin
                rd_hold            <= acc[pe_add_number];
                acc[pe_add_number] <= 16'd0;
            end
            rpipe            <= {rpipe[1:0], pe_rounder_en};
            pe_rounder_valid <= rpipe[1];
            if (rpipe[1]) pe_data_out <= rd_hold;
        end
    end

    // Result and done monitor
    always @(negedge clk) begin
        if (res_valid) begin
            res_q.push_back(res_data);
            slot_q.push_back(res_slot);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One job: a = (k+1).0, b = (slot+1) << bsh, so slot j sums to K(K+1)/2 * (j+1) << bsh
    task automatic run_job(input string name, input logic [7:0] k, input logic [3:0] s,
                           input bit toggle, input int bsh, input bit mid_start,
                           output int mac_cycles);
        int ns, total, idx, budget, res_base, done_base, kk, tri_v;
        bit phase, acc_now;
        logic [15:0] got_d, exp_d;
        logic [3:0]  got_s;
        ns        = (s > 4'd7) ? 8 : int'(s) + 1;
        kk        = int'(k) + 1;
        total     = kk * ns;
        tri_v     = (kk * (kk + 1)) / 2;
        res_base  = res_q.size();
        done_base = done_cnt;
        bubble_err = 0;
        @(posedge clk); #1;
        cfg_k = k; cfg_slots = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; mac_cycles = 0; phase = 1'b0; budget = 0;
        while (idx < total && budget < 2000) begin
            op_valid = toggle ? ~phase : 1'b1;
            phase    = ~phase;
            op_a     = 16'((idx / ns + 1) << 9);
            op_b     = 16'((idx % ns + 1) << bsh);
            start    = mid_start && (idx == 2);
            if (start) begin
                cfg_k = 8'd0; cfg_slots = 4'd0;
            end
            @(negedge clk);
            acc_now = op_valid && op_ready;
            @(posedge clk); #1;
            if (!op_valid && pe_keep !== 1'b1) bubble_err++;
            if (acc_now) idx++;
            mac_cycles++;
            budget++;
        end
        op_valid = 1'b0;
        start    = 1'b0;
        check({name, "_accepts"}, 32'(idx), 32'(total));
        @(negedge clk);
        check({name, "_op_ready_after"}, 32'(op_ready), 32'd0);
        budget = 0;
        while (done_cnt == done_base && budget < 500) begin
            @(negedge clk); #1;
            budget++;
        end
        check({name, "_done_seen"}, 32'(done_cnt - done_base), 32'd1);
        @(negedge clk); @(negedge clk); #1;
        check({name, "_done_once"}, 32'(done_cnt - done_base), 32'd1);
        check({name, "_res_count"}, 32'(res_q.size() - res_base), 32'(ns));
        for (int j = 0; j < ns; j++) begin
            got_d = (res_base + j < res_q.size()) ? res_q[res_base + j] : 16'hDEAD;
            got_s = (res_base + j < slot_q.size()) ? slot_q[res_base + j] : 4'hF;
            exp_d = 16'((tri_v * (j + 1)) << bsh);
            check($sformatf("%s_data%0d", name, j), 32'(got_d), 32'(exp_d));
            check($sformatf("%s_slot%0d", name, j), 32'(got_s), 32'(j));
        end
    endtask

    initial begin
        int mc;
        rst_n = 1'b0; start = 1'b0; cfg_k = 8'd0; cfg_slots = 4'd0;
        op_valid = 1'b0; op_a = 16'd0; op_b = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_keep", 32'(pe_keep), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rounder_en", 32'(pe_rounder_en), 32'd0);
        rst_n = 1'b1;

        run_job("k1s1", 8'd0, 4'd0, 1'b0, 10, 1'b0, mc);

        run_job("k4s8", 8'd3, 4'd7, 1'b0, 8, 1'b0, mc);
        check("k4s8_mac_cycles", 32'(mc), 32'd32);

        run_job("k4s2", 8'd3, 4'd1, 1'b0, 8, 1'b0, mc);
        run_job("k4s2_stall", 8'd3, 4'd1, 1'b1, 8, 1'b0, mc);
        check("stall_bubble_keep", 32'(bubble_err), 32'd0);
        check("stall_mac_cycles", 32'(mc), 32'd15);
`ifdef PE_SCHED_PERF_EN
        check("perf_stall_cnt", 32'(perf_stall_cnt), 32'd7);
`endif

        run_job("mid_start", 8'd2, 4'd2, 1'b0, 8, 1'b1, mc);

        run_job("clamp", 8'd1, 4'hF, 1'b0, 8, 1'b0, mc);
        run_job("b2b", 8'd0, 4'd2, 1'b0, 8, 1'b0, mc);

        // Asynchronous reset in the middle of a MAC phase
        @(posedge clk); #1;
        cfg_k = 8'd3; cfg_slots = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_valid = 1'b1; op_a = 16'h0200; op_b = 16'h0200;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_op_ready", 32'(op_ready), 32'd0);
        check("mid_rst_keep", 32'(pe_keep), 32'd1);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        op_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
